// File: rtl/alu_dm_pipe_hs.sv
// ALU->DM pipeline stage register with valid/ready handshake, flush,
// optional two-entry skid buffer and a saturating stall counter.
module alu_dm_pipe_hs #(
  parameter int DATA_W      = 32,
  parameter int RD_W        = 5,
  parameter int SKID        = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      aluResult_ALU,
  input  logic [DATA_W-1:0]      op2_ALU,
  input  logic [RD_W-1:0]        rd_ALU,
  input  logic                   isWb_ALU,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      aluResult_DM,
  output logic [DATA_W-1:0]      op2_DM,
  output logic [RD_W-1:0]        rd_DM,
  output logic                   isWb_DM,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] op2;
    logic [RD_W-1:0]   rd;
    logic              wb;
  } ent_t;

  ent_t                   w_in;
  ent_t                   r_m;
  logic                   r_mv;
  logic                   w_acc;
  logic                   w_drain;
  logic [STALL_CNT_W-1:0] r_stall;

  assign w_in    = '{alu: aluResult_ALU, op2: op2_ALU,
                     rd: rd_ALU, wb: isWb_ALU};
  assign w_acc   = in_valid & in_ready;
  assign w_drain = r_mv & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      ent_t r_s;
      logic r_sv;

      // Ready comes straight from the skid valid flop.
      assign in_ready = !r_sv;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_mv <= 1'b0;
          r_sv <= 1'b0;
          r_m  <= '0;
          r_s  <= '0;
        end else if (flush) begin
          r_mv <= 1'b0;
          r_sv <= 1'b0;
        end else if (!r_mv || w_drain) begin
          if (r_sv) begin
            r_m  <= r_s;
            r_mv <= 1'b1;
            if (w_acc) r_s <= w_in;
            else       r_sv <= 1'b0;
          end else begin
            r_mv <= w_acc;
            if (w_acc) r_m <= w_in;
          end
        end else if (w_acc) begin
          r_s  <= w_in;
          r_sv <= 1'b1;
        end
      end
    end else begin : g_noskid
      assign in_ready = !r_mv | out_ready;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_mv <= 1'b0;
          r_m  <= '0;
        end else if (flush) begin
          r_mv <= 1'b0;
        end else if (w_acc) begin
          r_m  <= w_in;
          r_mv <= 1'b1;
        end else if (w_drain) begin
          r_mv <= 1'b0;
        end
      end
    end
  endgenerate

  // Flush does not touch the counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if (r_mv && !out_ready && (r_stall != '1)) begin
      r_stall <= r_stall + STALL_CNT_W'(1);
    end
  end

  assign out_valid    = r_mv;
  assign aluResult_DM = r_m.alu;
  assign op2_DM       = r_m.op2;
  assign rd_DM        = r_m.rd;
  assign isWb_DM      = r_mv & r_m.wb;
  assign stall_cnt    = r_stall;

endmodule

// File: tb/tb_alu_dm_pipe_hs.sv
// Bench for alu_dm_pipe_hs: SKID=1 (4-bit counter) and SKID=0 instances
// driven in lockstep, checked by a FIFO-level model plus directed vectors.
module tb_alu_dm_pipe_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready, isWb_ALU;
  logic [31:0] aluResult_ALU, op2_ALU;
  logic [4:0]  rd_ALU;

  logic        rdy1, ov1, wb1;
  logic [31:0] alu1, op21;
  logic [4:0]  rd1;
  logic [3:0]  st1;

  logic        rdy0, ov0, wb0;
  logic [31:0] alu0, op20;
  logic [4:0]  rd0;
  logic [15:0] st0;

  alu_dm_pipe_hs #(.SKID(1), .STALL_CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1),
    .aluResult_ALU(aluResult_ALU), .op2_ALU(op2_ALU),
    .rd_ALU(rd_ALU), .isWb_ALU(isWb_ALU),
    .out_valid(ov1), .out_ready(out_ready),
    .aluResult_DM(alu1), .op2_DM(op21), .rd_DM(rd1),
    .isWb_DM(wb1), .stall_cnt(st1)
  );

  alu_dm_pipe_hs #(.SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0),
    .aluResult_ALU(aluResult_ALU), .op2_ALU(op2_ALU),
    .rd_ALU(rd_ALU), .isWb_ALU(isWb_ALU),
    .out_valid(ov0), .out_ready(out_ready),
    .aluResult_DM(alu0), .op2_DM(op20), .rd_DM(rd0),
    .isWb_DM(wb0), .stall_cnt(st0)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wb;
  } ent_t;

  // Model index 0 = SKID=0 (capacity 1), 1 = SKID=1 (capacity 2)
  ent_t mq[2][2];
  int   msz[2]   = '{0, 0};
  ent_t mheld[2];
  int   mcnt[2]  = '{0, 0};
  int   cmax[2]  = '{65535, 15};

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic bit mready(input int i);
    if (i == 1) return msz[1] < 2;
    return (msz[0] == 0) || out_ready;
  endfunction

  task automatic model_edge(input int i, input bit rdy);
    if (rst) begin
      msz[i] = 0;
      mheld[i] = '0;
      mcnt[i] = 0;
    end else begin
      if (msz[i] > 0 && !out_ready && mcnt[i] < cmax[i]) mcnt[i]++;
      if (flush) begin
        msz[i] = 0;
      end else begin
        if (msz[i] > 0 && out_ready) begin
          mq[i][0] = mq[i][1];
          msz[i]--;
        end
        if (in_valid && rdy) begin
          mq[i][msz[i]] = '{alu: aluResult_ALU, op2: op2_ALU,
                            rd: rd_ALU, wb: isWb_ALU};
          msz[i]++;
        end
      end
      if (msz[i] > 0) mheld[i] = mq[i][0];
    end
  endtask

  task automatic check_post();
    chk("m1.ov",  ov1,  msz[1] > 0);
    chk("m1.ir",  rdy1, mready(1));
    chk("m1.alu", alu1, mheld[1].alu);
    chk("m1.op2", op21, mheld[1].op2);
    chk("m1.rd",  rd1,  mheld[1].rd);
    chk("m1.wb",  wb1,  (msz[1] > 0) && mheld[1].wb);
    chk("m1.st",  st1,  mcnt[1]);
    chk("m0.ov",  ov0,  msz[0] > 0);
    chk("m0.ir",  rdy0, mready(0));
    chk("m0.alu", alu0, mheld[0].alu);
    chk("m0.op2", op20, mheld[0].op2);
    chk("m0.rd",  rd0,  mheld[0].rd);
    chk("m0.wb",  wb0,  (msz[0] > 0) && mheld[0].wb);
    chk("m0.st",  st0,  mcnt[0]);
  endtask

  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] a, input logic [31:0] o,
                      input logic [4:0] d, input logic w,
                      input logic ordy);
    bit q0, q1;
    rst = r; flush = f; in_valid = iv;
    aluResult_ALU = a; op2_ALU = o; rd_ALU = d;
    isWb_ALU = w; out_ready = ordy;
    #1;
    q0 = mready(0);
    q1 = mready(1);
    if (!r) begin
      chk("pre.ir0", rdy0, q0);
      chk("pre.ir1", rdy1, q1);
    end
    @(posedge clk);
    model_edge(0, q0);
    model_edge(1, q1);
    #1;
    check_post();
  endtask

  typedef struct {
    logic        r, f, iv;
    logic [31:0] a;
    logic        ordy;
    logic        eov, eir;
    logic [31:0] ealu;
    logic [3:0]  est;
  } vec_t;

  vec_t tv[12];

  initial begin
    // Backpressure into the skid, then flush with both entries full
    tv[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 4'd0};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 32'hA, 4'd0};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 32'hA, 4'd1};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 32'hA, 4'd2};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 32'hA, 4'd3};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 32'hB, 4'd3};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 32'hC, 4'd3};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hC, 4'd3};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 32'h1, 1'b0, 1'b1, 1'b1, 32'h1, 4'd3};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 32'h2, 1'b0, 1'b1, 1'b0, 32'h1, 4'd4};
    tv[10] = '{1'b0, 1'b1, 1'b1, 32'h3, 1'b0, 1'b0, 1'b1, 32'h1, 4'd5};
    tv[11] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1, 4'd5};

    for (int k = 0; k < 12; k++) begin
      step(tv[k].r, tv[k].f, tv[k].iv, tv[k].a, ~tv[k].a,
           5'(k), 1'b1, tv[k].ordy);
      chk($sformatf("tv%0d.ov", k),  ov1,  tv[k].eov);
      chk($sformatf("tv%0d.ir", k),  rdy1, tv[k].eir);
      chk($sformatf("tv%0d.alu", k), alu1, tv[k].ealu);
      chk($sformatf("tv%0d.wb", k),  wb1,  tv[k].eov);
      chk($sformatf("tv%0d.st", k),  st1,  tv[k].est);
    end

    // Counter saturation on the 4-bit instance, then reset clears it
    step(1'b0, 1'b0, 1'b1, 32'h9, 32'h0, 5'd9, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++)
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("sat.st1", st1, 4'd15);
    chk("sat.ov1", ov1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("sat.rst.st1", st1, 4'd0);
    chk("sat.rst.ov1", ov1, 1'b0);

    // Full-rate stream with out_ready held high
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 32'((k + 1) * 16), 32'(k), 5'(k + 1),
           1'b1, 1'b1);
      chk($sformatf("strm%0d.alu1", k), alu1, 32'((k + 1) * 16));
      chk($sformatf("strm%0d.rd1", k),  rd1,  5'(k + 1));
      chk($sformatf("strm%0d.ov1", k),  ov1,  1'b1);
      chk($sformatf("strm%0d.ir1", k),  rdy1, 1'b1);
      chk($sformatf("strm%0d.alu0", k), alu0, 32'((k + 1) * 16));
      chk($sformatf("strm%0d.st1", k),  st1,  4'd0);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    chk("strm.end.ov1", ov1, 1'b0);
    chk("strm.end.hold", alu1, 32'h40);

    // SKID=0 replace-on-drain without a bubble
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 5'd2, 1'b1, 1'b0);
    chk("rep.pre.alu0", alu0, 32'h55);
    step(1'b0, 1'b0, 1'b1, 32'h66, 32'h0, 5'd3, 1'b1, 1'b1);
    chk("rep.ov0",  ov0,  1'b1);
    chk("rep.alu0", alu0, 32'h66);

    // Mid-stream reset
    step(1'b0, 1'b0, 1'b1, 32'h70, 32'h1, 5'd3, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h71, 32'h2, 5'd7, 1'b1, 1'b1);
    chk("mrst.rd1",  rd1,  5'd0);
    chk("mrst.wb1",  wb1,  1'b0);
    chk("mrst.ov1",  ov1,  1'b0);
    chk("mrst.ir1",  rdy1, 1'b1);
    chk("mrst.rd0",  rd0,  5'd0);
    chk("mrst.ov0",  ov0,  1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h72, 32'h3, 5'd7, 1'b1, 1'b1);
    chk("mrst.nxt.ov1",  ov1,  1'b1);
    chk("mrst.nxt.alu1", alu1, 32'h72);
    chk("mrst.nxt.rd1",  rd1,  5'd7);
    chk("mrst.nxt.wb1",  wb1,  1'b1);

    // Randomised traffic against the model
    for (int k = 0; k < 600; k++) begin
      step(($urandom % 60) == 0, ($urandom % 25) == 0,
           ($urandom % 4) != 0, $urandom, $urandom,
           5'($urandom), 1'($urandom), ($urandom % 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
